// File: rtl/mux_pkg.sv
// Shared constants and elaboration-time helpers for the K-to-1 selector tree.
package mux_pkg;

    localparam int MUX_RADIX = 4;

    // Select width for n candidates, never narrower than one bit.
    function automatic int clog2_safe(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // Number of nodes feeding level l of the tree.
    function automatic int lvl_count(input int k, input int l);
        int n;
        n = k;
        for (int i = 0; i < l; i++) begin
            n = (n + MUX_RADIX - 1) / MUX_RADIX;
        end
        return n;
    endfunction

    // Offset of level l inside the flattened node vector.
    function automatic int lvl_offset(input int k, input int l);
        int o;
        o = 0;
        for (int i = 0; i < l; i++) begin
            o = o + lvl_count(k, i);
        end
        return o;
    endfunction

endpackage

// File: rtl/mux_4x1_cell.sv
// Combinational 4:1 selector cell used at every full level of the tree.
module mux_4x1_cell
    import mux_pkg::*;
(
    input  logic [MUX_RADIX-1:0] d,
    input  logic [1:0]           s,
    output logic                 o
);

    assign o = d[s];

endmodule

// File: rtl/mux_64_1.sv
// K-to-1 single-bit multiplexer: balanced tree of 4:1 cells feeding one
// output register, with zero forced for out-of-range selects.
module mux_64_1
    import mux_pkg::*;
#(
    parameter  int K     = 64,
    localparam int SEL_W = clog2_safe(K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [K-1:0]     a,
    input  logic [SEL_W-1:0] sel,
    input  logic             in_valid,
    output logic             y,
    output logic             out_valid
);

    localparam int NLVL4 = SEL_W / 2;
    localparam int TOTAL = lvl_offset(K, NLVL4 + 1);
    localparam int OFIN  = lvl_offset(K, NLVL4);

    // All tree nodes flattened level by level; level 0 is the input bus.
    logic [TOTAL-1:0] w_node;
    logic             w_tree;
    logic             w_oor;
    logic             r_y;
    logic             r_out_valid;

    assign w_node[K-1:0] = a;

    for (genvar l = 0; l < NLVL4; l++) begin : g_lvl
        localparam int CIN  = lvl_count(K, l);
        localparam int OIN  = lvl_offset(K, l);
        localparam int COUT = lvl_count(K, l + 1);
        localparam int OOUT = lvl_offset(K, l + 1);
        for (genvar c = 0; c < COUT; c++) begin : g_cell
            logic [MUX_RADIX-1:0] w_d;
            for (genvar j = 0; j < MUX_RADIX; j++) begin : g_in
                // Missing inputs of a partial group read as zero.
                if (c * MUX_RADIX + j < CIN) begin : g_live
                    assign w_d[j] = w_node[OIN + c * MUX_RADIX + j];
                end else begin : g_tie
                    assign w_d[j] = 1'b0;
                end
            end
            mux_4x1_cell u_cell (
                .d (w_d),
                .s (sel[2 * l + 1 : 2 * l]),
                .o (w_node[OOUT + c])
            );
        end
    end

    // An odd select width leaves exactly two nodes for a final 2:1 on the MSB.
    if ((SEL_W % 2) == 1) begin : g_last2
        assign w_tree = sel[SEL_W - 1] ? w_node[OFIN + 1] : w_node[OFIN];
    end else begin : g_last1
        assign w_tree = w_node[OFIN];
    end

    if (K == (1 << SEL_W)) begin : g_full
        assign w_oor = 1'b0;
    end else begin : g_part
        assign w_oor = ({1'b0, sel} >= (SEL_W + 1)'(K));
    end

    // Output register: y loads only on valid input, out_valid tracks in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y         <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_y <= w_oor ? 1'b0 : w_tree;
            end
        end
    end

    assign y         = r_y;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_64_1.sv
// Self-checking bench for mux_64_1 at K=64 and K=48 against a bit-pick model.
module tb_mux_64_1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] a64 = 64'h0;
    logic [5:0]  sel64 = 6'd0;
    logic        v64 = 1'b0;
    logic        y64, ov64;
    logic [47:0] a48 = 48'h0;
    logic [5:0]  sel48 = 6'd0;
    logic        v48 = 1'b0;
    logic        y48, ov48;

    logic m_y64 = 1'b0, m_v64 = 1'b0, m_y48 = 1'b0, m_v48 = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    mux_64_1 #(.K(64)) dut64 (
        .clk(clk), .rst(rst), .a(a64), .sel(sel64),
        .in_valid(v64), .y(y64), .out_valid(ov64)
    );

    mux_64_1 #(.K(48)) dut48 (
        .clk(clk), .rst(rst), .a(a48), .sel(sel48),
        .in_valid(v48), .y(y48), .out_valid(ov48)
    );

    always #5 clk = ~clk;

    function automatic logic pick(input logic [255:0] bus, input int idx, input int k);
        if (idx >= k) return 1'b0;
        return bus[idx];
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs presented, then compare.
    task automatic tick();
        if (rst) begin
            m_y64 = 1'b0; m_v64 = 1'b0; m_y48 = 1'b0; m_v48 = 1'b0;
        end else begin
            m_v64 = v64;
            if (v64) m_y64 = pick({192'h0, a64}, int'(sel64), 64);
            m_v48 = v48;
            if (v48) m_y48 = pick({208'h0, a48}, int'(sel48), 48);
        end
        @(posedge clk);
        #1;
        check("y64", y64, m_y64);
        check("ov64", ov64, m_v64);
        check("y48", y48, m_y48);
        check("ov48", ov48, m_v48);
    endtask

    initial begin
        logic [63:0] walk;
        // Reset held with live inputs.
        rst = 1'b1; a64 = '1; sel64 = 6'd5; v64 = 1'b1;
        a48 = '1; sel48 = 6'd5; v48 = 1'b1;
        tick();
        check("rst_y_c1", y64, 1'b0);
        tick();
        check("rst_y_c2", y64, 1'b0);
        check("rst_ov_c2", ov64, 1'b0);
        rst = 1'b0;
        tick();
        check("rel_y", y64, 1'b1);
        check("rel_ov", ov64, 1'b1);

        // Directed walk over every select value.
        walk = 64'hA5A5_0F0F_FFFF_0001;
        a64 = walk;
        for (int s = 0; s < 64; s++) begin
            sel64 = 6'(s);
            tick();
            check("walk", y64, walk[s]);
        end
        sel64 = 6'd0;  tick(); check("walk_s0", y64, 1'b1);
        sel64 = 6'd1;  tick(); check("walk_s1", y64, 1'b0);
        sel64 = 6'd16; tick(); check("walk_s16", y64, 1'b1);
        sel64 = 6'd63; tick(); check("walk_s63", y64, 1'b1);
        sel64 = 6'd62; tick(); check("walk_s62", y64, 1'b0);

        // One-hot through every tree path, with unselected bits unknown.
        for (int i = 0; i < 64; i++) begin
            a64 = 64'h1 << i;
            sel64 = 6'(i);
            tick();
            check("onehot_hit", y64, 1'b1);
            sel64 = 6'((i + 1) % 64);
            tick();
            check("onehot_miss", y64, 1'b0);
            a64 = 'x;
            a64[i] = 1'b1;
            sel64 = 6'(i);
            tick();
            check("x_other", y64, 1'b1);
        end

        // Hold while in_valid is low.
        a64 = 64'h8000_0000_0000_0000; sel64 = 6'd63; v64 = 1'b1;
        tick();
        check("hold_load", y64, 1'b1);
        a64 = 64'h0; sel64 = 6'd0; v64 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("hold_y", y64, 1'b1);
            check("hold_ov", ov64, 1'b0);
        end

        // Back-to-back alternating selects.
        a64 = 64'h2; v64 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sel64 = 6'(c % 2);
            tick();
            check("b2b_y", y64, 1'((c % 2) == 1));
            check("b2b_ov", ov64, 1'b1);
        end

        // Mid-stream reset discards the sample presented with it.
        a64 = '1; sel64 = 6'd3; rst = 1'b1;
        tick();
        check("mid_rst_y", y64, 1'b0);
        rst = 1'b0;

        // K=48: top in-range bit and out-of-range select.
        a48 = 48'h8000_0000_0000; sel48 = 6'd47; v48 = 1'b1;
        tick();
        check("k48_s47", y48, 1'b1);
        a48 = '1; sel48 = 6'd50;
        tick();
        check("k48_oor", y48, 1'b0);
        sel48 = 6'd63;
        tick();
        check("k48_oor63", y48, 1'b0);

        // Random traffic on both instances.
        for (int c = 0; c < 64; c++) begin
            a64 = {32'($urandom()), 32'($urandom())};
            sel64 = 6'($urandom_range(63, 0));
            v64 = 1'($urandom_range(1, 0));
            a48 = 48'({32'($urandom()), 32'($urandom())});
            sel48 = 6'($urandom_range(63, 0));
            v48 = 1'($urandom_range(3, 0) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
